conv_window_gen3x3: RTL

Streaming 3x3 sliding-window generator that produces the input patches consumed by the Convolution3x3 engine. It accepts one raster-order pixel per handshake and keeps two line buffers plus a 3x3 window register. For every fully-populated window (no padding) it presents a packed 3x3 patch on a valid/ready output. It sits between the image source (DMA/stream) and the convolution stage.

---
 rtl/conv_window_gen3x3.sv | 128 ++++++++++++
 1 files changed

// File: rtl/conv_window_gen3x3.sv
// Streaming 3x3 sliding-window generator: two line buffers plus a 3x3 window register,
// emitting one packed patch per fully-populated (unpadded) window over valid/ready.
module conv_window_gen3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_pixel,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic [9*DATA_W-1:0]        win_patch,
    output logic                       win_last,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef logic [DATA_W-1:0] pix_t;

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Window element (r,c) lives at index r*3+c, so the packed array is the patch itself.
    logic [8:0][DATA_W-1:0] win_q, win_d;

    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [RW-1:0] wrow_q, wrow_d;
    logic [CW-1:0] wcol_q, wcol_d;

    // lb0 holds the previous row, lb1 the row above it.
    pix_t lb0_q [IMG_W];
    pix_t lb1_q [IMG_W];

    logic accept;
    logic col_wrap;
    logic frame_end;
    pix_t lb0_rd;
    pix_t lb1_rd;

    assign in_ready  = !valid_q || win_ready;
    assign accept    = in_valid && in_ready;
    assign col_wrap  = (col_q == COL_LAST);
    assign frame_end = col_wrap && (row_q == ROW_LAST);
    assign lb0_rd    = lb0_q[col_q];
    assign lb1_rd    = lb1_q[col_q];

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        valid_d = valid_q;
        last_d  = last_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r*3 + 0] = win_q[r*3 + 1];
                win_d[r*3 + 1] = win_q[r*3 + 2];
            end
            win_d[2] = lb1_rd;
            win_d[5] = lb0_rd;
            win_d[8] = in_pixel;

            col_d = col_wrap ? '0 : col_q + CW'(1);
            if (col_wrap) begin
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end

            valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            wrow_d  = row_q - RW'(1);
            wcol_d  = col_q - CW'(1);
            last_d  = frame_end;
        end else if (valid_q && win_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
        end
    end

    // NOTE: line buffers carry no reset; each entry is rewritten before any window that
    // reads it can be emitted, so clearing them would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[col_q] <= lb0_rd;
            lb0_q[col_q] <= in_pixel;
        end
    end

    assign win_valid = valid_q;
    assign win_patch = win_q;
    assign win_last  = last_q;
    assign win_row   = wrow_q;
    assign win_col   = wcol_q;

endmodule
